aes_round_ctrl: RTL and testbench

//  Control FSM for the AES-128 encryption FSMD. Accepts a plaintext block via valid/ready,

---
 rtl/aes_round_ctrl_if.sv | 45 ++++
 rtl/aes_round_ctrl.sv | 133 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Bundles the AES round controller's handshakes, counter hooks and
// datapath strobes.
//   master : the controller (drives in_ready, out_valid, key_req, cnt_*,
//            ld_in, op_*, err)
//   slave  : datapath / key expansion / round counter side
// Handshakes: a transfer happens in any cycle where the valid-side signal
// and its ready/ack partner are both 1 at the rising edge. Here that means
// in_valid&in_ready, out_valid&out_ready and key_req&key_ack. A valid or
// request, once raised, stays up until that transfer happens (clr aside).
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if #(
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          key_req;
  logic          key_ack;
  logic [CW-1:0] rnd_cnt;
  logic          rnd_pen;
  logic          rnd_last;
  logic          cnt_en;
  logic          cnt_clr;
  logic          ld_in;
  logic          op_sub;
  logic          op_shift;
  logic          op_mix;
  logic          op_addkey;
  logic          err;

  modport master (
    input  in_valid, out_ready, key_ack, rnd_cnt, rnd_pen, rnd_last,
    output in_ready, out_valid, key_req, cnt_en, cnt_clr, ld_in,
           op_sub, op_shift, op_mix, op_addkey, err
  );

  modport slave (
    output in_valid, out_ready, key_ack, rnd_cnt, rnd_pen, rnd_last,
    input  in_ready, out_valid, key_req, cnt_en, cnt_clr, ld_in,
           op_sub, op_shift, op_mix, op_addkey, err
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Control FSM for an AES-128 encryption FSMD. It accepts a plaintext block,
// then sequences the initial AddRoundKey, NR-1 full rounds and a final round
// without MixColumns. After that it presents the ciphertext. Every step
// waits for its round key from key expansion (key_req/key_ack).
// Ports:
//   clk     : rising-edge clock
//   clr     : synchronous active-high reset
//   bus     : aes_round_ctrl_if.master (handshakes, counter, strobes, err)
//   state_o : current FSM state, for observation only
// All bus outputs except err are combinational decodes of the state and
// the inputs, so every strobe takes effect at the next rising edge.
// err is a sticky register.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int CW = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  aes_round_ctrl_if.master      bus,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;

  assign state_o = state_q;
  assign bus.err = err_q;

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.key_req   = 1'b0;
    bus.cnt_en    = 1'b0;
    bus.cnt_clr   = 1'b0;
    bus.ld_in     = 1'b0;
    bus.op_sub    = 1'b0;
    bus.op_shift  = 1'b0;
    bus.op_mix    = 1'b0;
    bus.op_addkey = 1'b0;

    if (clr) begin
      // Hold the counter at zero while in reset. Every other output stays quiet.
      bus.cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            bus.ld_in   = 1'b1;
            bus.cnt_clr = 1'b1;
            state_d     = S_INIT;
          end
        end
        S_INIT: begin
          bus.key_req = 1'b1;
          if (bus.key_ack) begin
            bus.op_addkey = 1'b1;
            bus.cnt_en    = 1'b1;
            state_d       = S_ROUND;
          end
        end
        S_ROUND: begin
          bus.key_req = 1'b1;
          if (bus.key_ack) begin
            bus.op_sub    = 1'b1;
            bus.op_shift  = 1'b1;
            bus.op_mix    = 1'b1;
            bus.op_addkey = 1'b1;
            bus.cnt_en    = 1'b1;
            // A full round must run with a count between 1 and NR-1.
            // Anything else means the counter and the FSM have drifted
            // apart. Flag it and keep going.
            if (bus.rnd_cnt == '0 || bus.rnd_cnt >= CW'(NR)) begin
              err_d = 1'b1;
            end
            if (bus.rnd_pen) begin
              state_d = S_FINAL;
            end
          end
        end
        S_FINAL: begin
          bus.key_req = 1'b1;
          if (bus.key_ack) begin
            if (bus.rnd_last) begin
              bus.op_sub    = 1'b1;
              bus.op_shift  = 1'b1;
              bus.op_addkey = 1'b1;
              state_d       = S_DONE;
            end else begin
              // The counter disagrees with the FSM about the final round.
              // Drop the block rather than emit a wrong ciphertext.
              err_d       = 1'b1;
              bus.cnt_clr = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        S_DONE: begin
          bus.out_valid = 1'b1;
          if (bus.out_ready) begin
            bus.cnt_clr = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Bench for aes_round_ctrl. It models the round counter the FSM controls and
// the key-expansion handshake, which stalls per key request as
// stall_plan[] prescribes. Each finished block is checked against the
// totals and latency that the AES round schedule implies.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [2:0]    state_dbg;
  logic [CW-1:0] cnt_q;
  bit            corrupt_cnt = 1'b0;
  bit            kill_last   = 1'b0;
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            stall_plan[NR+1];
  logic [7:0]    exp_q[$];

  aes_round_ctrl_if #(.CW(CW)) bus ();

  aes_round_ctrl #(.NR(NR), .CW(CW)) dut (
    .clk     (clk),
    .clr     (clr),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // round counter environment
  always @(posedge clk) begin
    if (bus.cnt_clr)     cnt_q <= '0;
    else if (bus.cnt_en) cnt_q <= cnt_q + 1'b1;
  end
  assign bus.rnd_cnt  = corrupt_cnt ? '0 : cnt_q;
  assign bus.rnd_pen  = (cnt_q == CW'(NR - 1));
  assign bus.rnd_last = kill_last ? 1'b0 : (cnt_q == CW'(NR));

  task automatic clear_plan();
    for (int i = 0; i <= NR; i++) stall_plan[i] = 0;
  endtask

  // Drives one block from handshake to completion and checks the schedule.
  task automatic send_block(input string tag, input int done_hold, input bit bad_final);
    int k, left, first_ov, ov_cycles, done_cnt, viol, exp_lat;
    int n_sub, n_shift, n_mix, n_add, n_en;
    logic [CW-1:0] cnt_at_done;
    logic clr_at_done;
    bit finished, ov_seen, acked;
    logic [7:0] exp_v;
    exp_lat = NR + 2;
    for (int i = 0; i <= NR; i++) exp_lat += stall_plan[i];
    exp_q.push_back(exp_lat[7:0]);
    k = 0; left = stall_plan[0]; first_ov = -1; ov_cycles = 0; done_cnt = 0; viol = 0;
    n_sub = 0; n_shift = 0; n_mix = 0; n_add = 0; n_en = 0;
    finished = 0; ov_seen = 0; cnt_at_done = '0; clr_at_done = 1'b0;

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.key_ack   = 1'($urandom_range(0, 1));
    bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_ready: got %b want 1", tag, bus.in_ready);
    end
    n_cmp++;
    if ({bus.ld_in, bus.cnt_clr} !== 2'b11) begin
      n_fail++; $display("FAIL %s accept: ld_in,cnt_clr got %b want 11", tag, {bus.ld_in, bus.cnt_clr});
    end

    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      @(negedge clk);
      bus.in_valid = bus.in_ready ? 1'b0 : 1'($urandom_range(0, 1));
      if (bus.key_req) begin
        if (left > 0) begin bus.key_ack = 1'b0; left--; end
        else bus.key_ack = 1'b1;
      end else begin
        bus.key_ack = 1'($urandom_range(0, 1));
      end
      if (bus.out_valid) begin
        bus.out_ready = (done_cnt >= done_hold);
        done_cnt++;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      #1;
      acked = bus.key_req && bus.key_ack;
      n_sub   += int'(bus.op_sub);
      n_shift += int'(bus.op_shift);
      n_mix   += int'(bus.op_mix);
      n_add   += int'(bus.op_addkey);
      n_en    += int'(bus.cnt_en);
      if ((bus.op_sub | bus.op_shift | bus.op_mix | bus.op_addkey | bus.cnt_en) && !acked) viol++;
      if (bus.in_ready && bus.out_valid) viol++;
      if (bus.out_valid) begin
        if (!ov_seen) first_ov = cyc;
        ov_seen = 1; ov_cycles++;
      end
      if (bus.out_valid && bus.out_ready) begin
        cnt_at_done = cnt_q; clr_at_done = bus.cnt_clr; finished = 1;
      end
      if (acked) begin
        if (k == NR && bad_final) finished = 1;
        k++;
        if (k <= NR) left = stall_plan[k];
      end
    end

    exp_v = exp_q.pop_front();
    n_cmp++;
    if (!finished) begin
      n_fail++; $display("FAIL %s timeout: block did not complete within 200 cycles", tag);
    end
    n_cmp++;
    if (viol != 0) begin
      n_fail++; $display("FAIL %s protocol: got %0d violations want 0", tag, viol);
    end
    n_cmp++;
    if (n_mix != NR - 1) begin
      n_fail++; $display("FAIL %s op_mix_count: got %0d want %0d", tag, n_mix, NR - 1);
    end
    n_cmp++;
    if (n_en != NR) begin
      n_fail++; $display("FAIL %s cnt_en_count: got %0d want %0d", tag, n_en, NR);
    end
    n_cmp++;
    if (n_add != (bad_final ? NR : NR + 1)) begin
      n_fail++; $display("FAIL %s op_addkey_count: got %0d want %0d", tag, n_add, bad_final ? NR : NR + 1);
    end
    n_cmp++;
    if (n_sub != (bad_final ? NR - 1 : NR) || n_shift != n_sub) begin
      n_fail++; $display("FAIL %s op_sub_shift_count: got %0d/%0d want %0d", tag, n_sub, n_shift, bad_final ? NR - 1 : NR);
    end
    if (bad_final) begin
      n_cmp++;
      if (ov_seen) begin
        n_fail++; $display("FAIL %s no_out_valid: got out_valid at cycle %0d want never", tag, first_ov);
      end
    end else begin
      n_cmp++;
      if (first_ov != int'(exp_v)) begin
        n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, first_ov, exp_v);
      end
      n_cmp++;
      if (ov_cycles != done_hold + 1) begin
        n_fail++; $display("FAIL %s out_valid_hold: got %0d want %0d", tag, ov_cycles, done_hold + 1);
      end
      n_cmp++;
      if (cnt_at_done !== CW'(NR) || clr_at_done !== 1'b1) begin
        n_fail++; $display("FAIL %s done_count: cnt %0d clr %b want %0d clr 1", tag, cnt_at_done, clr_at_done, NR);
      end
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_err);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.key_ack = 1'b0; bus.out_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state_dbg !== 3'd0) begin
      n_fail++; $display("FAIL %s idle: in_ready %b out_valid %b state %0d want 1 0 0", tag, bus.in_ready, bus.out_valid, state_dbg);
    end
    n_cmp++;
    if (bus.err !== exp_err) begin
      n_fail++; $display("FAIL %s err: got %b want %b", tag, bus.err, exp_err);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1; bus.in_valid = 1'b1; bus.key_ack = 1'b1; bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.cnt_clr, bus.in_ready, bus.out_valid, bus.key_req, bus.ld_in} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_during: got %b want 10000", {bus.cnt_clr, bus.in_ready, bus.out_valid, bus.key_req, bus.ld_in});
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0; bus.key_ack = 1'b0; bus.out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({bus.op_sub, bus.op_shift, bus.op_mix, bus.op_addkey, bus.cnt_en, bus.cnt_clr} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000", {bus.op_sub, bus.op_shift, bus.op_mix, bus.op_addkey, bus.cnt_en, bus.cnt_clr});
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_after: in_ready %b out_valid %b err %b want 1 0 0", bus.in_ready, bus.out_valid, bus.err);
    end
  endtask

  task automatic test_nominal();
    clear_plan();
    send_block("nominal", 0, 1'b0);
    check_idle("nominal", 1'b0);
  endtask

  task automatic test_key_stall();
    clear_plan();
    stall_plan[0] = 3;
    stall_plan[5] = 2;
    send_block("key_stall", 0, 1'b0);
    check_idle("key_stall", 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_plan();
    send_block("done_hold", 5, 1'b0);
    send_block("back_to_back", 0, 1'b0);
    check_idle("back_to_back", 1'b0);
  endtask

  task automatic test_clr_mid();
    clear_plan();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.key_ack = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (cnt_q == CW'(4) && bus.key_req) break;
    end
    n_cmp++;
    if (cnt_q !== CW'(4)) begin
      n_fail++; $display("FAIL clr_mid_reach: got cnt %0d want 4", cnt_q);
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if ({bus.op_sub, bus.op_shift, bus.op_mix, bus.op_addkey, bus.cnt_en, bus.key_req, bus.in_ready, bus.out_valid, bus.cnt_clr} !== 9'b000000001) begin
      n_fail++; $display("FAIL clr_mid_outputs: got %b want 000000001",
        {bus.op_sub, bus.op_shift, bus.op_mix, bus.op_addkey, bus.cnt_en, bus.key_req, bus.in_ready, bus.out_valid, bus.cnt_clr});
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_cmp++;
    if (state_dbg !== 3'd0 || bus.in_ready !== 1'b1 || cnt_q !== '0) begin
      n_fail++; $display("FAIL clr_mid_idle: state %0d in_ready %b cnt %0d want 0 1 0", state_dbg, bus.in_ready, cnt_q);
    end
    send_block("after_clr", 0, 1'b0);
    check_idle("after_clr", 1'b0);
  endtask

  task automatic test_round_err();
    clear_plan();
    corrupt_cnt = 1'b1;
    send_block("round_err", 0, 1'b0);
    check_idle("round_err", 1'b1);
    corrupt_cnt = 1'b0;
    test_reset();
  endtask

  task automatic test_faulty_last();
    clear_plan();
    kill_last = 1'b1;
    send_block("faulty_last", 0, 1'b1);
    check_idle("faulty_last", 1'b1);
    kill_last = 1'b0;
    test_reset();
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i <= NR; i++) stall_plan[i] = $urandom_range(0, 2);
      send_block($sformatf("random%0d", b), $urandom_range(0, 3), 1'b0);
    end
    check_idle("random", 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.key_ack = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_key_stall();
    test_back_to_back();
    test_clr_mid();
    test_round_err();
    test_faulty_last();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
